// File: rtl/mapa_server.sv
// ============================================================================
//  Module   : mapa_server
//  Purpose  : Tile-map store for the renderer. Registered read port, req/ack
//             write port for game logic, and a clear sequencer that fills the
//             map after reset or on request.
//  Options  : `MAPA_BORDER_EN - out-of-range reads return BORDER_COR, not 0
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mapa_server #(
    parameter int         MAP_W      = 40,
    parameter int         MAP_H      = 30,
    parameter int         STARVE_MAX = 8,
    parameter logic [5:0] BORDER_COR = 6'b000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] mapa_x,
    input  logic [9:0] mapa_y,
    input  logic       mapa_read,
    output logic [5:0] mapa_cor,
    input  logic       wr_req,
    input  logic [9:0] wr_x,
    input  logic [9:0] wr_y,
    input  logic [5:0] wr_cor,
    output logic       wr_ack,
    input  logic       clear_req,
    input  logic [5:0] clear_cor,
    output logic       busy
);

    localparam int CELLS  = MAP_W * MAP_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

`ifdef MAPA_BORDER_EN
    localparam logic       BORDER_EN = 1'b1;
    localparam logic [5:0] OOR_COR   = BORDER_COR;
`else
    localparam logic       BORDER_EN = 1'b0;
    localparam logic [5:0] OOR_COR   = BORDER_COR & 6'h00;
`endif

    logic [0:0]        state_q,    state_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [5:0]        fill_q,     fill_d;
    logic [SCNT_W-1:0] starve_q,   starve_d;
    logic [5:0]        mapa_cor_q, mapa_cor_d;
    logic              wr_ack_q,   wr_ack_d;

    logic [5:0]        mem_q [CELLS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [5:0]        mem_wdata;

    logic              rd_in, wr_in, write_win;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    always_comb begin
        rd_in   = (mapa_x < 10'(MAP_W)) && (mapa_y < 10'(MAP_H));
        wr_in   = (wr_x < 10'(MAP_W)) && (wr_y < 10'(MAP_H));
        rd_addr = ADDR_W'(mapa_y) * ADDR_W'(MAP_W) + ADDR_W'(mapa_x);
        wr_addr = ADDR_W'(wr_y) * ADDR_W'(MAP_W) + ADDR_W'(wr_x);
        // A pending write steals the port only once reads have starved it long enough
        write_win = wr_req && (!mapa_read || (starve_q == SCNT_W'(STARVE_MAX)));

        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        starve_d   = starve_q;
        mapa_cor_d = mapa_cor_q;
        wr_ack_d   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_addr;
        mem_wdata  = wr_cor;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = fill_q;
                if (mapa_read) begin
                    mapa_cor_d = (BORDER_EN && !rd_in) ? OOR_COR : fill_q;
                end
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (write_win) begin
                    wr_ack_d = 1'b1;
                    starve_d = '0;
                    mem_we   = wr_in;
                end else if (mapa_read) begin
                    mapa_cor_d = rd_in ? mem_q[rd_addr] : OOR_COR;
                    if (wr_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
                if (clear_req) begin
                    fill_d  = clear_cor;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            fill_q     <= '0;
            starve_q   <= '0;
            mapa_cor_q <= '0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            starve_q   <= starve_d;
            mapa_cor_q <= mapa_cor_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign mapa_cor = mapa_cor_q;
    assign wr_ack   = wr_ack_q;
    assign busy     = (state_q == S_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_mapa_server.sv
// ============================================================================
//  Module   : tb_mapa_server
//  Purpose  : Self-checking bench for mapa_server against an array model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mapa_server;

    localparam int         W      = 40;
    localparam int         H      = 30;
    localparam int         CELLS  = W * H;
    localparam int         STARVE = 8;
    localparam logic [5:0] BCOR   = 6'h03;
`ifdef MAPA_BORDER_EN
    localparam logic [5:0] OOR_EXP = BCOR;
`else
    localparam logic [5:0] OOR_EXP = 6'h00;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] mapa_x, mapa_y;
    logic       mapa_read;
    logic [5:0] mapa_cor;
    logic       wr_req;
    logic [9:0] wr_x, wr_y;
    logic [5:0] wr_cor;
    logic       wr_ack;
    logic       clear_req;
    logic [5:0] clear_cor;
    logic       busy;

    mapa_server #(
        .MAP_W(W), .MAP_H(H), .STARVE_MAX(STARVE), .BORDER_COR(BCOR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mapa_x(mapa_x), .mapa_y(mapa_y), .mapa_read(mapa_read), .mapa_cor(mapa_cor),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_cor(wr_cor), .wr_ack(wr_ack),
        .clear_req(clear_req), .clear_cor(clear_cor), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] model [CELLS];
    logic [5:0] exp_cor;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_model(input logic [5:0] c);
        for (int i = 0; i < CELLS; i++) model[i] = c;
    endtask

    task automatic do_read(input int x, input int y, input string tag);
        mapa_x = 10'(x); mapa_y = 10'(y); mapa_read = 1'b1;
        tick();
        mapa_read = 1'b0;
        exp_cor = (x < W && y < H) ? model[y * W + x] : OOR_EXP;
        chk(tag, mapa_cor, exp_cor);
    endtask

    task automatic do_write(input int x, input int y, input logic [5:0] c, input string tag);
        wr_x = 10'(x); wr_y = 10'(y); wr_cor = c; wr_req = 1'b1;
        tick();
        chk(tag, wr_ack, 1'b1);
        wr_req = 1'b0;
        if (x < W && y < H) model[y * W + x] = c;
        tick();
        chk({tag, "_ackpulse"}, wr_ack, 1'b0);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, n, CELLS);
    endtask

    task automatic starve_run(input logic [5:0] c);
        int ack_k = -1;
        wr_x = 10'd10; wr_y = 10'd10; wr_cor = c; wr_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mapa_x = 10'($urandom_range(0, W - 1));
            mapa_y = 10'($urandom_range(0, H - 1));
            mapa_read = 1'b1;
            tick();
            if (wr_ack) begin
                chk("starve_hold", mapa_cor, exp_cor);
                ack_k = k;
                break;
            end
            exp_cor = model[int'(mapa_y) * W + int'(mapa_x)];
            chk("starve_read", mapa_cor, exp_cor);
        end
        mapa_read = 1'b0;
        wr_req    = 1'b0;
        chk("starve_denied", ack_k, STARVE);
        model[10 * W + 10] = c;
        tick();
        do_read(10, 10, "starve_cell");
    endtask

    initial begin
        int         n;
        logic       ack_in_clear;
        logic [5:0] c;

        rst_n = 1'b0; mapa_x = '0; mapa_y = '0; mapa_read = 1'b0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_cor = '0;
        clear_req = 1'b0; clear_cor = '0;
        exp_cor = '0;
        fill_model(6'h00);

        #3;
        chk("rst_busy", busy, 1'b1);
        chk("rst_cor", mapa_cor, 6'h00);
        chk("rst_ack", wr_ack, 1'b0);
        tick();
        rst_n = 1'b1;
        wait_clear("clear_len_reset");
        do_read(5, 7, "read_after_reset");

        do_write(3, 4, 6'h2A, "wr_3_4");
        do_read(3, 4, "rd_3_4");

        // Write then read the same cell in the ack cycle
        wr_x = 10'd6; wr_y = 10'd2; wr_cor = 6'h1B; wr_req = 1'b1;
        tick();
        chk("wr_6_2_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        model[2 * W + 6] = 6'h1B;
        do_read(6, 2, "rd_in_ack_cycle");

        for (int i = 0; i < 25; i++) begin
            do_write($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                     6'($urandom_range(0, 63)), "wr_rand");
        end
        do_write(40, 3, 6'h3E, "wr_oor_x");
        do_write(1023, 0, 6'h3D, "wr_oor_big");
        do_write(2, 30, 6'h3C, "wr_oor_y");
        do_read(0, 4, "rd_alias_0_4");
        do_read(23, 25, "rd_alias_23_25");
        for (int i = 0; i < 25; i++) begin
            do_read($urandom_range(0, W - 1), $urandom_range(0, H - 1), "rd_rand");
        end

        starve_run(6'h15);
        starve_run(6'($urandom_range(0, 63)));

        do_read(40, 0, "rd_oor_40_0");
        do_read(0, 30, "rd_oor_0_30");

        // Requested clear, with a write waiting and a second clear_req ignored
        clear_req = 1'b1; clear_cor = 6'h3F;
        tick();
        clear_req = 1'b0;
        chk("clr_busy", busy, 1'b1);
        wr_x = 10'd1; wr_y = 10'd1; wr_cor = 6'h11; wr_req = 1'b1;
        ack_in_clear = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            mapa_read = (n == 100 || n == 300);
            mapa_x = 10'd39; mapa_y = 10'd29;
            clear_req = (n == 200); clear_cor = 6'h05;
            tick();
            n++;
            mapa_read = 1'b0;
            clear_req = 1'b0;
            if (wr_ack) ack_in_clear = 1'b1;
            if (n == 101) chk("clr_read_mid", mapa_cor, 6'h3F);
            if (n == 301) chk("clr_read_after_ignored", mapa_cor, 6'h3F);
        end
        chk("clear_len_req", n, CELLS);
        chk("no_ack_in_clear", ack_in_clear, 1'b0);
        fill_model(6'h3F);
        tick();
        chk("wr_after_clear_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        model[1 * W + 1] = 6'h11;
        do_read(1, 1, "rd_1_1");
        do_read(39, 29, "rd_39_29");
        do_read(20, 15, "rd_20_15");

        // Reset in the middle of a clear with a write pending
        c = 6'h2C;
        clear_req = 1'b1; clear_cor = c;
        tick();
        clear_req = 1'b0;
        wr_x = 10'd7; wr_y = 10'd7; wr_cor = 6'h09; wr_req = 1'b1;
        repeat (500) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_cor", mapa_cor, 6'h00);
        chk("midrst_ack", wr_ack, 1'b0);
        wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_clear("clear_len_midrst");
        fill_model(6'h00);
        n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                mapa_x = 10'(x); mapa_y = 10'(y); mapa_read = 1'b1;
                tick();
                if (mapa_cor !== 6'h00) n++;
            end
        end
        mapa_read = 1'b0;
        chk("midrst_cells_nonzero", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mapa_server.md
# mapa_server

Tile-map store and responder for the renderer's map-read interface. Holds one colour per block of the screen, answers `mapa_x`/`mapa_y`/`mapa_read` lookups with a registered `mapa_cor`, and accepts cell writes from game logic through a req/ack handshake. Includes a hardware clear sequencer that fills the whole map after reset or on request. Sits between the game-logic block, which writes, and the renderer, which reads.

## Interface
- `MAP_W`, 40, map width in blocks (640 / 16)
- `MAP_H`, 30, map height in blocks (480 / 16)
- `STARVE_MAX`, 8, consecutive cycles a pending write may lose to reads before it is forced through
- `BORDER_COR`, 6'b000000, colour for out-of-range reads (used only with `MAPA_BORDER_EN`)
- `clk`  in  1  system clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `mapa_x`  in  10  block column requested
- `mapa_y`  in  10  block row requested
- `mapa_read`  in  1  read strobe, sampled every cycle
- `mapa_cor`  out  6  colour of the requested cell, registered
- `wr_req`  in  1  write request, held until `wr_ack`
- `wr_x`  in  10  write column, stable while `wr_req` is high
- `wr_y`  in  10  write row, stable while `wr_req` is high
- `wr_cor`  in  6  write colour, stable while `wr_req` is high
- `wr_ack`  out  1  one-cycle pulse when the write is retired
- `clear_req`  in  1  pulse; start filling the map with `clear_cor`
- `clear_cor`  in  6  fill colour, sampled with `clear_req`
- `busy`  out  1  high while clearing

## Operation
- Storage: single-port array of MAP_W*MAP_H entries, 6 bits each. Address = y*MAP_W + x. Address width = $clog2(MAP_W*MAP_H).
- FSM states:
  - CLEAR: one cell is written per cycle with the latched fill colour. The address counter runs 0 to MAP_W*MAP_H-1, then the FSM goes to IDLE.
  - IDLE: serves reads and writes.
- Reset: async entry to CLEAR, with fill colour 0 and counter 0.
- `clear_req` in IDLE: latches `clear_cor`, resets the counter and enters CLEAR the next cycle. `clear_req` while already in CLEAR is ignored.
- Reads in CLEAR:
  - Not stalled.
  - `mapa_cor` returns the latched fill colour regardless of address.
- Arbitration in IDLE when `mapa_read` and `wr_req` are both high:
  - The read wins and the starve counter increments.
  - Once the counter reaches STARVE_MAX, the write wins that cycle. The read is dropped and `mapa_cor` holds its previous value.
  - The counter clears on every retired write.
- Write alone in IDLE: retired the same cycle.
- Writes are never retired in CLEAR. They stay pending until IDLE.
- Out-of-range write (`wr_x` ≥ MAP_W or `wr_y` ≥ MAP_H): acked, array untouched.
- Out-of-range read: returns 0, or `BORDER_COR` (see Configuration). The array is not accessed.

## Timing
- Reset values: `mapa_cor`=0, `wr_ack`=0, `busy`=1, starve counter 0.
- Read latency: `mapa_read` high in cycle N → `mapa_cor` valid from cycle N+1 and held until the next served read.
- Write handshake:
  - `wr_ack` is high for exactly the cycle after the retiring edge.
  - The requester deasserts `wr_req`, or presents new data, in the cycle `wr_ack` is seen.
  - A read of the same cell issued in the ack cycle returns the new colour.
- Clear duration: exactly MAP_W*MAP_H cycles (1200 by default) from CLEAR entry. `busy` falls the cycle after the last cell is written.
- Reset mid-clear or mid-handshake: the clear restarts from address 0 with fill colour 0, and a pending write is lost without ack.

## Configuration
- `MAPA_BORDER_EN`
  - Defined: out-of-range reads return `BORDER_COR`, and reads during CLEAR at out-of-range addresses also return `BORDER_COR`.
  - Undefined: out-of-range reads return 0, and `BORDER_COR` is unused.

## Test plan
- Reset release, `mapa_read`=0 → `busy` high for 1200 cycles, then low; reading (5,7) returns 0 one cycle after the strobe.
- After clear, `wr_req` (3,4,6'h2A) with `mapa_read`=0 → `wr_ack` on the next cycle; a read of (3,4) returns 6'h2A.
- `mapa_read` held high continuously with `wr_req` (10,10,6'h15) → the write is retired after exactly STARVE_MAX=8 denied cycles; `mapa_cor` holds across the stolen cycle.
- `clear_req` with `clear_cor`=6'h3F, then a read of (39,29) during the clear → returns 6'h3F; a `wr_req` issued mid-clear is acked only after `busy` falls.
- Read (40,0) → 0 without `MAPA_BORDER_EN`; `BORDER_COR`=6'h03 returns 6'h03 with it.
- Assert `rst_n` low at cycle 500 of a clear → `busy` stays high, the clear restarts, and 1200 cycles later all cells read 0.
